// File: rtl/ysyx_22050550_ifu_pkg.sv
// Shared encodings for the instruction fetch unit.
package ysyx_22050550_ifu_pkg;

  localparam int unsigned REG_BUS_W = 64;
  localparam int unsigned INST_W    = 32;
  localparam int unsigned FAULT_W   = 2;

  localparam logic [INST_W-1:0] IFU_NOP_INST = 32'h0000_0013;

  localparam logic [FAULT_W-1:0] FAULT_NONE     = 2'b00;
  localparam logic [FAULT_W-1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [FAULT_W-1:0] FAULT_BUS      = 2'b10;

  typedef enum logic [1:0] {
    IFU_IDLE = 2'd0,
    IFU_AR   = 2'd1,
    IFU_R    = 2'd2,
    IFU_HOLD = 2'd3
  } ifu_state_e;

endpackage

// File: rtl/ysyx_22050550_ifu_fsm.sv
// Fetch control: state register and in-flight discard flag.
module ysyx_22050550_ifu_fsm
  import ysyx_22050550_ifu_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       misaligned,
  input  logic       flush,
  input  logic       arready,
  input  logic       rvalid,
  input  logic       id_ready,
  output ifu_state_e state,
  output logic       drop
);

  // State and drop update; a redirect while a read is outstanding marks its response for discard.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IFU_IDLE;
      drop  <= 1'b0;
    end else begin
      case (state)
        IFU_IDLE: state <= misaligned ? IFU_HOLD : IFU_AR;
        IFU_AR: begin
          if (flush)   drop  <= 1'b1;
          if (arready) state <= IFU_R;
        end
        IFU_R: begin
          if (rvalid) begin
            drop  <= 1'b0;
            state <= (drop || flush) ? IFU_IDLE : IFU_HOLD;
          end else if (flush) begin
            drop <= 1'b1;
          end
        end
        IFU_HOLD: if (flush || id_ready) state <= IFU_IDLE;
        default: state <= IFU_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/ysyx_22050550_ifu.sv
// Instruction fetch unit: one outstanding AXI4-Lite read, result held for ID.
module ysyx_22050550_ifu
  import ysyx_22050550_ifu_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 64,
  parameter int unsigned       DATA_W   = REG_BUS_W,
  parameter logic [INST_W-1:0] NOP_INST = IFU_NOP_INST
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   in_pc,
  input  logic                flush,
  output logic                pc_advance,
  output logic [ADDR_W-1:0]   araddr,
  output logic                arvalid,
  input  logic                arready,
  input  logic [DATA_W-1:0]   rdata,
  input  logic [1:0]          rresp,
  input  logic                rvalid,
  output logic                rready,
  output logic [ADDR_W-1:0]   if_pc,
  output logic [INST_W-1:0]   if_inst,
  output logic [FAULT_W-1:0]  if_fault,
  output logic                if_valid,
  input  logic                id_ready
);

  ifu_state_e        state;
  logic              drop;
  logic              misaligned;
  logic [ADDR_W-1:0] req_pc;
  logic [INST_W-1:0] sel_word;

  assign misaligned = (in_pc[1:0] != 2'b00);
  assign sel_word   = req_pc[2] ? rdata[63:32] : rdata[31:0];

  // Handshake to ID completes in the same cycle it is accepted; flush overrides acceptance.
  assign pc_advance = (state == IFU_HOLD) && if_valid && id_ready && !flush;

  ysyx_22050550_ifu_fsm u_fsm (
    .clock      (clock),
    .reset      (reset),
    .misaligned (misaligned),
    .flush      (flush),
    .arready    (arready),
    .rvalid     (rvalid),
    .id_ready   (id_ready),
    .state      (state),
    .drop       (drop)
  );

  // Bus request and ID-facing datapath registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      req_pc   <= '0;
      araddr   <= '0;
      arvalid  <= 1'b0;
      rready   <= 1'b0;
      if_pc    <= '0;
      if_inst  <= NOP_INST;
      if_fault <= FAULT_NONE;
      if_valid <= 1'b0;
    end else begin
      case (state)
        IFU_IDLE: begin
          req_pc <= in_pc;
          if (misaligned) begin
            if_pc    <= in_pc;
            if_inst  <= NOP_INST;
            if_fault <= FAULT_MISALIGN;
            if_valid <= 1'b1;
          end else begin
            araddr  <= {in_pc[ADDR_W-1:3], 3'b000};
            arvalid <= 1'b1;
          end
        end
        IFU_AR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
          end
        end
        IFU_R: begin
          if (rvalid) begin
            rready <= 1'b0;
            if (!(drop || flush)) begin
              if_pc    <= req_pc;
              if_inst  <= (rresp != 2'b00) ? NOP_INST : sel_word;
              if_fault <= (rresp != 2'b00) ? FAULT_BUS : FAULT_NONE;
              if_valid <= 1'b1;
            end
          end
        end
        IFU_HOLD: begin
          if (flush || id_ready) if_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22050550_ifu.sv
// Directed bench for the instruction fetch unit.
module tb_ysyx_22050550_ifu;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clock = 1'b0;
  logic        reset;
  logic [63:0] in_pc;
  logic        flush;
  logic        pc_advance;
  logic [63:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [63:0] if_pc;
  logic [31:0] if_inst;
  logic [1:0]  if_fault;
  logic        if_valid;
  logic        id_ready;

  int n_chk  = 0;
  int n_pass = 0;

  ysyx_22050550_ifu dut (
    .clock      (clock),
    .reset      (reset),
    .in_pc      (in_pc),
    .flush      (flush),
    .pc_advance (pc_advance),
    .araddr     (araddr),
    .arvalid    (arvalid),
    .arready    (arready),
    .rdata      (rdata),
    .rresp      (rresp),
    .rvalid     (rvalid),
    .rready     (rready),
    .if_pc      (if_pc),
    .if_inst    (if_inst),
    .if_fault   (if_fault),
    .if_valid   (if_valid),
    .id_ready   (id_ready)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Advance to the next falling edge, then settle before sampling.
  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".if_valid"}, 64'(if_valid), 64'd0);
    check({tag, ".if_pc"},    if_pc,         64'd0);
    check({tag, ".if_inst"},  64'(if_inst),  64'(NOP));
    check({tag, ".if_fault"}, 64'(if_fault), 64'd0);
    check({tag, ".arvalid"},  64'(arvalid),  64'd0);
    check({tag, ".araddr"},   araddr,        64'd0);
    check({tag, ".pc_adv"},   64'(pc_advance), 64'd0);
  endtask

  initial begin
    reset    = 1'b0;
    in_pc    = 64'h8000_0000;
    flush    = 1'b0;
    arready  = 1'b1;
    rvalid   = 1'b1;
    rdata    = 64'h0000_0297_0010_0073;
    rresp    = 2'b00;
    id_ready = 1'b0;

    // Reset state
    step();
    check_reset_vals("rst");
    reset = 1'b1;                      // now in IDLE

    // Basic fetch at 0x80000000
    step();
    check("t1.arvalid", 64'(arvalid), 64'd1);
    check("t1.araddr",  araddr, 64'h8000_0000);
    step();
    check("t1.rready",  64'(rready), 64'd1);
    check("t1.valid_c2", 64'(if_valid), 64'd0);
    step();
    check("t1.valid_c3", 64'(if_valid), 64'd1);
    check("t1.inst",    64'(if_inst), 64'h0010_0073);
    check("t1.pc",      if_pc, 64'h8000_0000);
    check("t1.fault",   64'(if_fault), 64'd0);
    check("t1.noadv",   64'(pc_advance), 64'd0);
    id_ready = 1'b1;
    #1;
    check("t1.adv",     64'(pc_advance), 64'd1);
    step();
    check("t1.adv_off", 64'(pc_advance), 64'd0);
    check("t1.valid_off", 64'(if_valid), 64'd0);
    id_ready = 1'b0;

    // Upper word at 0x80000004, with ID stalling 5 cycles
    in_pc = 64'h8000_0004;
    step();
    check("t2.araddr", araddr, 64'h8000_0000);
    step();
    step();
    check("t2.inst", 64'(if_inst), 64'h0000_0297);
    check("t2.pc",   if_pc, 64'h8000_0004);
    for (int i = 0; i < 5; i++) begin
      step();
      check("t2.hold_valid", 64'(if_valid), 64'd1);
      check("t2.hold_inst",  64'(if_inst), 64'h0000_0297);
      check("t2.hold_noadv", 64'(pc_advance), 64'd0);
    end
    id_ready = 1'b1;
    #1;
    check("t2.adv", 64'(pc_advance), 64'd1);
    step();
    check("t2.adv_once", 64'(pc_advance), 64'd0);
    id_ready = 1'b0;

    // Flush in R with delayed response
    in_pc  = 64'h8000_0008;
    rvalid = 1'b0;
    step();                            // AR
    step();                            // R
    check("t3.rready", 64'(rready), 64'd1);
    flush = 1'b1;
    in_pc = 64'h8000_0100;
    step();
    flush = 1'b0;
    step();
    step();
    rvalid = 1'b1;
    step();                            // discarded, back in IDLE
    check("t3.valid_drop", 64'(if_valid), 64'd0);
    check("t3.rready_off", 64'(rready), 64'd0);
    step();
    check("t3.arvalid", 64'(arvalid), 64'd1);
    check("t3.araddr",  araddr, 64'h8000_0100);
    step();
    step();
    check("t3.valid", 64'(if_valid), 64'd1);
    check("t3.inst",  64'(if_inst), 64'h0010_0073);
    check("t3.pc",    if_pc, 64'h8000_0100);
    // Flush and id_ready together: flush wins
    id_ready = 1'b1;
    flush    = 1'b1;
    #1;
    check("t3.flush_wins", 64'(pc_advance), 64'd0);
    step();
    check("t3.flush_clr", 64'(if_valid), 64'd0);
    flush    = 1'b0;
    id_ready = 1'b0;

    // Misaligned PC: no bus request, fault 01
    in_pc = 64'h8000_0002;
    step();
    check("t4.noar",  64'(arvalid), 64'd0);
    check("t4.valid", 64'(if_valid), 64'd1);
    check("t4.fault", 64'(if_fault), 64'd1);
    check("t4.inst",  64'(if_inst), 64'(NOP));
    check("t4.pc",    if_pc, 64'h8000_0002);
    id_ready = 1'b1;
    step();
    id_ready = 1'b0;

    // Bus error response: fault 10 with NOP
    in_pc = 64'h8000_0004;
    rresp = 2'b10;
    step();
    step();
    step();
    check("t5.fault", 64'(if_fault), 64'd2);
    check("t5.inst",  64'(if_inst), 64'(NOP));
    id_ready = 1'b1;
    step();
    id_ready = 1'b0;
    rresp    = 2'b00;

    // Reset during R, stray rvalid afterwards
    in_pc = 64'h8000_0008;
    step();                            // AR
    step();                            // R
    reset = 1'b0;
    #1;
    check_reset_vals("rstR");
    check("rstR.rready", 64'(rready), 64'd0);
    step();
    reset = 1'b1;                      // IDLE with rvalid high
    step();
    check("t6.valid", 64'(if_valid), 64'd0);
    check("t6.arvalid", 64'(arvalid), 64'd1);
    check("t6.araddr", araddr, 64'h8000_0008);
    step();
    step();
    check("t6.inst", 64'(if_inst), 64'h0010_0073);
    check("t6.pc",   if_pc, 64'h8000_0008);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
